// File: rtl/rx_uart.sv
// 8N1 UART receiver: oversamples the async rx pin, validates the start bit at mid-bit,
// samples data/stop at bit centres and reports good bytes (rx_valid) or bad stop bits (frame_err).
module rx_uart #(
    parameter int CLKS_PER_BIT = 1252,
    parameter int CNT_W        = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       sh_reg, sh_next;
    logic [7:0]       rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic [1:0]       sync_reg;
    logic             rx_s;

    // Two-flop synchronizer; flops reset to the idle (high) line level.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (!reset) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= rx;
                end
            end else begin : g_rest
                always_ff @(posedge clock) begin
                    if (!reset) sync_reg[gi] <= 1'b1;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            sh_reg        <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            sh_reg        <= sh_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        sh_next        = sh_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt_reg == HALF_M1) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // A start bit that is no longer low at mid-bit is treated as a glitch.
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == BIT_M1) begin
                    cnt_next = '0;
                    sh_next  = {rx_s, sh_reg[7:1]};
                    if (bit_idx_reg == 3'd7) state_next   = STOP;
                    else                     bit_idx_next = bit_idx_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == BIT_M1) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        rx_data_next  = sh_reg;
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HI;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                // A held-low (break) line must return high before a new start is accepted.
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: directed frames, expected events queued by the driver
// and checked by an independent monitor on the falling clock edge.
module tb_rx_uart;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        logic       chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;

    rx_uart #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic push_exp(input logic is_err, input logic [7:0] d, input logic lat);
        exp_t e;
        e.is_err  = is_err;
        e.data    = d;
        e.chk_lat = lat;
        exp_q.push_back(e);
    endtask

    // Monitor: every output strobe must match the oldest queued expectation.
    always @(negedge clock) begin
        if (rx_valid || frame_err) begin
            exp_t e;
            int   lat;
            check("valid_err_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, rx_valid, frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                $display("event %s rx_data=%02h expected=%02h", frame_err ? "frame_err" : "rx_valid",
                         rx_data, e.data);
                if (e.chk_lat) begin
                    lat = cyc - start_cyc;
                    check("latency_in_window", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
                    $display("latency %0d clocks", lat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clock);
        #1;

        // 2: good byte with latency check
        push_exp(1'b0, 8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        repeat (10) @(posedge clock);
        #1;

        // 3: short glitch rejected
        rx = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h A5);
        $display("glitch rejected rx_data=%02h busy=%0d", rx_data, busy);

        // 4: bad stop bit followed by a break
        push_exp(1'b1, 8'hA5, 1'b0);
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clock);
        #1;
        check("break_busy_held", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("break_busy_released", {31'd0, busy}, 32'd0);
        check("break_rx_data", {24'd0, rx_data}, 32'h A5);
        repeat (10) @(posedge clock);
        #1;

        // 5: back-to-back frames
        push_exp(1'b0, 8'h00, 1'b0);
        push_exp(1'b0, 8'hFF, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (10) @(posedge clock);
        #1;

        // 6: reset during bit 4 of 0x5A, then a clean 0xC3
        begin
            logic [7:0] d;
            d = 8'h5A;
            drive_bit(1'b0);
            for (int i = 0; i < 4; i++) drive_bit(d[i]);
            rx = d[4];
            repeat (CPB / 2) @(posedge clock);
            #1;
        end
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge clock);
        #1;
        push_exp(1'b0, 8'hC3, 1'b0);
        send_frame(8'hC3, 1'b1);
        repeat (30) @(posedge clock);
        #1;

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
